fetch_ctrl: RTL

//  Instruction-fetch sequencer for the 8-bit-address / 16-bit-word instruction memory.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and default program-fetch constants.
// Imported by fetch_ctrl and available to decode/execute.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 16;

  localparam logic [FETCH_ADDR_W-1:0]  FETCH_PC_STEP    = 8'd2;
  localparam logic [FETCH_ADDR_W-1:0]  FETCH_RESET_PC   = 8'h00;
  localparam logic [FETCH_INSTR_W-1:0] FETCH_HALT_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the IM address and hands fetched
// words to decode through a one-entry valid/ready buffer with redirect and halt support.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                  ADDR_W     = FETCH_ADDR_W,
  parameter int                  INSTR_W    = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0]   PC_STEP    = ADDR_W'(FETCH_PC_STEP),
  parameter logic [ADDR_W-1:0]   RESET_PC   = ADDR_W'(FETCH_RESET_PC),
  parameter logic [INSTR_W-1:0]  HALT_INSTR = INSTR_W'(FETCH_HALT_INSTR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_instr,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  input  logic               if_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic [ADDR_W-1:0]  if_pc_q;
  logic               if_valid_q;

  logic [ADDR_W-1:0]  br_pc_d;
  logic [ADDR_W-1:0]  pc_inc_d;
  logic               can_capture_d;

  // Redirect targets are forced word-aligned; PC increment wraps modulo 2^ADDR_W.
  assign br_pc_d       = br_target & ~ADDR_W'(1);
  assign pc_inc_d      = pc_q + PC_STEP;
  assign can_capture_d = !if_valid_q || if_ready;

  // FSM, program counter and fetch buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      if_instr_q <= {INSTR_W{1'b0}};
      if_pc_q    <= {ADDR_W{1'b0}};
      if_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q    <= RESET_PC;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (br_taken) begin
            pc_q       <= br_pc_d;
            if_valid_q <= 1'b0;
          end else if (can_capture_d) begin
            if_instr_q <= im_instr;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_inc_d;
            if (im_instr == HALT_INSTR) begin
              state_q <= S_HALT;
            end
          end
        end
        S_HALT: begin
          if (br_taken) begin
            pc_q       <= br_pc_d;
            if_valid_q <= 1'b0;
            state_q    <= S_FETCH;
          end else begin
            if (if_valid_q && if_ready) begin
              if_valid_q <= 1'b0;
            end
            // Restart only once the halt marker has drained to decode.
            if (start && !if_valid_q) begin
              pc_q    <= RESET_PC;
              state_q <= S_FETCH;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign im_addr  = pc_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;
  assign halted   = (state_q == S_HALT) && !if_valid_q;

endmodule
